spmv_sparse_tx: RTL and testbench
=================================

Name: spmv_sparse_tx

Overview:
- Dense-to-sparse stream encoder that drives the SPMV engine's input interface (in_valid / weight_valid / in_row / in_col / in_data).
- Accepts one job as a dense element stream: the vector first, then the matrix in row-major order.
- Compresses each part to its nonzero entries and buffers the whole job.
- Replays the job as one gap-free burst: vector burst immediately followed by weight burst. SPMV clears its stored vector on any idle cycle, so the gap-free burst is required. The block then waits for SPMV out_finish before taking the next job.

Parameters:
- VEC_LEN, 32, dense vector length and matrix column count (2..32).
- MAT_ROWS, 32, matrix row count (1..32).
- MAX_V_NZ, 14, vector nonzero buffer depth (SPMV capacity).
- MAX_W_NZ, 64, matrix nonzero buffer depth.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  dense element valid.
- s_ready  out  1  element accepted when s_valid&s_ready.
- s_data  in  8  dense element value, unsigned.
- in_valid  out  1  vector nonzero strobe to SPMV.
- weight_valid  out  1  matrix nonzero strobe to SPMV.
- in_row  out  5  vector index (vector phase) or matrix row (weight phase).
- in_col  out  5  matrix column; 0 in vector phase.
- in_data  out  8  nonzero value.
- finish_in  in  1  SPMV out_finish.
- busy  out  1  high in every state except LOAD_VEC with zero elements accepted.
- job_done  out  1  one-cycle pulse at job completion.
- ovf  out  1  sticky overflow flag; cleared on first element of next job.

Behaviour:
- Reset is asynchronous on rst rising. Everything returns to LOAD_VEC: counters and buffer pointers 0; all outputs 0 except s_ready=1. Reset mid-burst drops both strobes in the same cycle.
- FSM states: LOAD_VEC, LOAD_MAT, SEND_VEC, SEND_MAT, WAIT_FIN.
  - LOAD_VEC: s_ready=1. Column counter c counts accepted elements 0..VEC_LEN-1. A nonzero element is written into the V-buffer as {c, data}. After element VEC_LEN-1 -> LOAD_MAT.
  - LOAD_MAT: s_ready=1. Row/col counters (r, c) run row-major with c wrapping at VEC_LEN. A nonzero element is written into the W-buffer as {r, c, data}. After element (MAT_ROWS-1, VEC_LEN-1): if W count is 0, pulse job_done the next cycle and go to LOAD_VEC; else -> SEND_VEC, or -> SEND_MAT if V count is 0.
  - s_ready=0 in SEND_VEC, SEND_MAT and WAIT_FIN.
  - SEND_VEC: one V entry per cycle; in_valid=1, in_row=index, in_col=0. The last entry is followed in the very next cycle by the first W entry (SEND_MAT); no idle cycle is allowed.
  - SEND_MAT: one W entry per cycle, in buffer (row-major) order; weight_valid=1. After the last entry -> WAIT_FIN with both strobes low.
  - WAIT_FIN: on finish_in=1, pulse job_done the next cycle and go to LOAD_VEC. finish_in is ignored in all other states.
- Output registering and latency:
  - All SPMV-facing outputs are registered.
  - The first in_valid (or weight_valid) appears 2 cycles after the handshake of the last dense element.
  - Burst length = V count + W count cycles, exactly.
- Overflow: a nonzero arriving when its buffer is full is dropped and ovf is set. Loading continues and the stored subset is still sent.
- At most one of in_valid / weight_valid is high in any cycle.
- Zero-valued elements are never emitted.

Optional Feature:
- Macro: SPMV_TX_COLFILTER_EN.
- Defined: LOAD_VEC builds a VEC_LEN-bit nonzero bitmap of the vector. In LOAD_MAT, a matrix nonzero whose column bit is 0 is discarded (its product would be 0). Discards neither occupy the W-buffer nor set ovf. If filtering leaves no W entries, the job ends with job_done and no burst.
- Undefined: no bitmap; every matrix nonzero is buffered.

Decomposition:
- Package spmv_pkg holds:
  - IDX_W=5, DATA_W=8 constants;
  - typedef spmv_v_ent_t {idx, data};
  - typedef spmv_w_ent_t {row, col, data};
  - enum spmv_tx_state_t.
- Sub-module spmv_tx_nzbuf: parameterised depth/width write-then-read buffer. It has push, pop, clear, count and full; spmv_sparse_tx instantiates it twice (V and W buffers).

Test Plan:
- Vector {3@idx2, 5@idx7, rest 0}; matrix nonzeros (0,2)=4 and (1,7)=6.
  - Expect in_valid for 2 cycles: (row2, 3), then (row7, 5).
  - Then, with no gap, weight_valid for 2 cycles: (0,2,4), then (1,7,6).
  - After finish_in, job_done pulses once.
- Vector with 16 nonzeros: first 14 emitted, ovf=1. A second clean job clears ovf on its first accepted element.
- All-zero matrix: no strobes at all; job_done one cycle after the last element; WAIT_FIN never entered.
- finish_in held high during SEND_MAT: ignored. Burst length equals the W count exactly; job_done only after a WAIT_FIN finish_in.
- Assert rst during SEND_MAT: strobes low immediately. Next job is accepted from element 0 with correct indices.
- With SPMV_TX_COLFILTER_EN: vector nonzero only at idx1, matrix nonzeros (0,1)=2 and (0,3)=9. Only (0,1,2) is emitted and ovf stays 0.

Source files
------------

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared widths, buffer entry types and transmitter states for the SPMV sparse encoder
package spmv_pkg;
  localparam int IDX_W = 5;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } spmv_v_ent_t;
  typedef struct packed {
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } spmv_w_ent_t;
  typedef enum logic [2:0] {LOAD_VEC, LOAD_MAT, SEND_VEC, SEND_MAT, WAIT_FIN} spmv_tx_state_t;
endpackage

// File: rtl/spmv_tx_nzbuf.sv
// spmv_tx_nzbuf: write-then-read nonzero entry buffer with count, full and last-read flags
module spmv_tx_nzbuf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  assign full = count == CW'(DEPTH);
  assign last = CW'(rd_ptr) + CW'(1) == count;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && !full) mem[count[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      count <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) count <= count + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/spmv_sparse_tx.sv
// spmv_sparse_tx: dense-to-sparse job encoder feeding SPMV as one gap-free burst (optional SPMV_TX_COLFILTER_EN column filter)
module spmv_sparse_tx
  import spmv_pkg::*;
#(
  parameter int VEC_LEN  = 32,
  parameter int MAT_ROWS = 32,
  parameter int MAX_V_NZ = 14,
  parameter int MAX_W_NZ = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              in_valid,
  output logic              weight_valid,
  output logic [IDX_W-1:0]  in_row,
  output logic [IDX_W-1:0]  in_col,
  output logic [DATA_W-1:0] in_data,
  input  logic              finish_in,
  output logic              busy,
  output logic              job_done,
  output logic              ovf
);
  localparam int VCW = $clog2(MAX_V_NZ + 1);
  localparam int WCW = $clog2(MAX_W_NZ + 1);
  spmv_tx_state_t state, state_nx;
  logic [IDX_W-1:0] r, c;
  logic [VCW-1:0] v_cnt;
  logic [WCW-1:0] w_cnt;
  logic hs, nz, last_c, last_r, w_keep, v_push, w_push, v_pop, w_pop;
  logic v_full, w_full, v_last, w_last, mat_done, w_none, job_end, drop;
  spmv_v_ent_t v_rd;
  spmv_w_ent_t w_rd;
  assign s_ready = state == LOAD_VEC || state == LOAD_MAT;
  assign busy = !(state == LOAD_VEC && c == '0);
  assign hs = s_valid && s_ready;
  assign nz = s_data != '0;
  assign last_c = c == IDX_W'(VEC_LEN - 1);
  assign last_r = r == IDX_W'(MAT_ROWS - 1);
`ifdef SPMV_TX_COLFILTER_EN
  logic [VEC_LEN-1:0] bmap;
  always_ff @(posedge clk or posedge rst)
    if (rst) bmap <= '0;
    else if (hs && state == LOAD_VEC) bmap[c] <= nz;
  assign w_keep = bmap[c];
`else
  assign w_keep = 1'b1;
`endif
  assign v_push = hs && state == LOAD_VEC && nz;
  assign w_push = hs && state == LOAD_MAT && nz && w_keep;
  assign v_pop = state == SEND_VEC;
  assign w_pop = state == SEND_MAT;
  assign drop = (v_push && v_full) || (w_push && w_full);
  assign mat_done = hs && state == LOAD_MAT && last_c && last_r;
  assign w_none = w_cnt == '0 && !w_push;
  assign job_end = (mat_done && w_none) || (state == WAIT_FIN && finish_in);
  spmv_tx_nzbuf #(.DEPTH(MAX_V_NZ), .WIDTH($bits(spmv_v_ent_t))) u_vbuf (
    .clk(clk), .rst(rst), .push(v_push), .pop(v_pop), .clear(job_end),
    .wr_data({c, s_data}), .rd_data(v_rd), .count(v_cnt), .full(v_full), .last(v_last)
  );
  spmv_tx_nzbuf #(.DEPTH(MAX_W_NZ), .WIDTH($bits(spmv_w_ent_t))) u_wbuf (
    .clk(clk), .rst(rst), .push(w_push), .pop(w_pop), .clear(job_end),
    .wr_data({r, c, s_data}), .rd_data(w_rd), .count(w_cnt), .full(w_full), .last(w_last)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_VEC: state_nx = hs && last_c ? LOAD_MAT : LOAD_VEC;
      LOAD_MAT: state_nx = !mat_done ? LOAD_MAT : w_none ? LOAD_VEC : v_cnt != '0 ? SEND_VEC : SEND_MAT;
      SEND_VEC: state_nx = v_last ? SEND_MAT : SEND_VEC;
      SEND_MAT: state_nx = w_last ? WAIT_FIN : SEND_MAT;
      WAIT_FIN: state_nx = finish_in ? LOAD_VEC : WAIT_FIN;
      default:  state_nx = LOAD_VEC;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD_VEC;
      r <= '0;
      c <= '0;
      ovf <= 1'b0;
      job_done <= 1'b0;
      in_valid <= 1'b0;
      weight_valid <= 1'b0;
      in_row <= '0;
      in_col <= '0;
      in_data <= '0;
    end else begin
      state <= state_nx;
      if (hs) c <= last_c ? '0 : c + 1'b1;
      if (hs && state == LOAD_MAT && last_c) r <= last_r ? '0 : r + 1'b1;
      ovf <= hs && state == LOAD_VEC && c == '0 ? 1'b0 : ovf | drop;
      job_done <= job_end;
      in_valid <= v_pop;
      weight_valid <= w_pop;
      in_row <= v_pop ? v_rd.idx : w_pop ? w_rd.row : '0;
      in_col <= w_pop ? w_rd.col : '0;
      in_data <= v_pop ? v_rd.data : w_pop ? w_rd.data : '0;
    end
endmodule

// File: tb/tb_spmv_sparse_tx.sv
// tb_spmv_sparse_tx: randomized and directed jobs checked against a queue-based model of the sparse burst
module tb_spmv_sparse_tx;
  localparam int VL = 32;
  localparam int MR = 32;
  localparam int MV = 14;
  localparam int MW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [7:0] s_data = '0;
  logic in_valid, weight_valid, busy, job_done, ovf;
  logic [4:0] in_row, in_col;
  logic [7:0] in_data;
  logic finish_in = 1'b0;
  spmv_sparse_tx #(.VEC_LEN(VL), .MAT_ROWS(MR), .MAX_V_NZ(MV), .MAX_W_NZ(MW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .in_valid(in_valid), .weight_valid(weight_valid), .in_row(in_row), .in_col(in_col),
    .in_data(in_data), .finish_in(finish_in), .busy(busy), .job_done(job_done), .ovf(ovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit w;
    int row;
    int col;
    int data;
  } ent_t;
  ent_t exp_q[$];
  ent_t mdl[$];
  int checks = 0;
  int errors = 0;
  int pcyc = 0;
  int due = 0;
  bit m_ovf;
  logic [7:0] vec [VL];
  logic [7:0] mat [MR][VL];
  always @(posedge clk) pcyc <= pcyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, pcyc);
    end
  endtask
  task automatic timeout(input string name);
    errors++;
    $display("FAIL %s: no progress within cycle budget", name);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "stopped on timeout");
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("strobe_exclusive", int'(in_valid && weight_valid), 0);
      if (exp_q.size() > 0 && pcyc >= due) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("in_valid", int'(in_valid), int'(!e.w));
        chk("weight_valid", int'(weight_valid), int'(e.w));
        chk("in_row", int'(in_row), e.row);
        chk("in_col", int'(in_col), e.col);
        chk("in_data", int'(in_data), e.data);
      end else
        chk("idle_strobe", int'(in_valid || weight_valid), 0);
    end
  task automatic build_model();
    ent_t e;
    ent_t wq[$];
    int vc = 0;
    bit keep;
    mdl.delete();
    m_ovf = 0;
    for (int i = 0; i < VL; i++)
      if (vec[i] != 0) begin
        if (vc < MV) begin
          e = '{1'b0, i, 0, int'(vec[i])};
          mdl.push_back(e);
          vc++;
        end else m_ovf = 1;
      end
    for (int rr = 0; rr < MR; rr++)
      for (int cc = 0; cc < VL; cc++) begin
`ifdef SPMV_TX_COLFILTER_EN
        keep = vec[cc] != 0;
`else
        keep = 1;
`endif
        if (mat[rr][cc] != 0 && keep) begin
          if (wq.size() < MW) begin
            e = '{1'b1, rr, cc, int'(mat[rr][cc])};
            wq.push_back(e);
          end else m_ovf = 1;
        end
      end
    if (wq.size() == 0) mdl.delete();
    else foreach (wq[i]) mdl.push_back(wq[i]);
  endtask
  task automatic clear_job();
    foreach (vec[i]) vec[i] = '0;
    foreach (mat[i, j]) mat[i][j] = '0;
  endtask
  task automatic rand_job(input int pv, input int pm);
    foreach (vec[i]) vec[i] = $urandom_range(0, 99) < pv ? 8'($urandom_range(1, 255)) : 8'd0;
    foreach (mat[i, j]) mat[i][j] = $urandom_range(0, 999) < pm ? 8'($urandom_range(1, 255)) : 8'd0;
  endtask
  task automatic run_job(input bit hold_fin, input bit rst_mid);
    int n = 0;
    int guard = 0;
    int total = VL + VL * MR;
    bit first = 1;
    logic [7:0] d;
    build_model();
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(s_ready), 1);
    while (n < total) begin
      d = n < VL ? vec[n] : mat[(n - VL) / VL][(n - VL) % VL];
      s_valid = $urandom_range(0, 3) != 0;
      s_data = s_valid ? d : 8'($urandom);
      if (s_valid && s_ready) begin
        if (n == total - 1) begin
          exp_q = mdl;
          due = pcyc + 2;
          finish_in = hold_fin;
        end
        n++;
      end
      @(posedge clk); #1;
      if (first && n == 1) begin
        chk("first_busy", int'(busy), 1);
        chk("first_ovf_clear", int'(ovf), 0);
        first = 0;
      end
      if (++guard > 20000) timeout("load");
    end
    s_valid = 1'b0;
    if (mdl.size() == 0) begin
      chk("empty_job_done", int'(job_done), 1);
      chk("empty_busy", int'(busy), 0);
      chk("empty_ready", int'(s_ready), 1);
      chk("empty_ovf", int'(ovf), int'(m_ovf));
      @(posedge clk); #1;
      chk("empty_done_single", int'(job_done), 0);
      chk("empty_still_ready", int'(s_ready), 1);
      return;
    end
    chk("send_ready", int'(s_ready), 0);
    guard = 0;
    while (exp_q.size() > 0) begin
      chk("done_early", int'(job_done), 0);
      if (rst_mid && weight_valid) begin
        rst = 1'b1;
        #1;
        chk("rst_in_valid", int'(in_valid), 0);
        chk("rst_weight_valid", int'(weight_valid), 0);
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_busy", int'(busy), 0);
        exp_q.delete();
        finish_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      finish_in = hold_fin && exp_q.size() > 1;
      @(posedge clk); #1;
      if (++guard > 200) timeout("burst");
    end
    finish_in = 1'b0;
    chk("burst_ovf", int'(ovf), int'(m_ovf));
    repeat ($urandom_range(0, 3)) begin
      chk("wait_no_done", int'(job_done), 0);
      chk("wait_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    finish_in = 1'b1;
    @(posedge clk); #1;
    finish_in = 1'b0;
    chk("fin_job_done", int'(job_done), 1);
    @(posedge clk); #1;
    chk("fin_done_single", int'(job_done), 0);
    chk("fin_ready", int'(s_ready), 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_valid", int'(in_valid), 0);
    chk("reset_weight_valid", int'(weight_valid), 0);
    chk("reset_job_done", int'(job_done), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_ready", int'(s_ready), 1);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    clear_job();
    vec[2] = 8'd3;
    vec[7] = 8'd5;
    mat[0][2] = 8'd4;
    mat[1][7] = 8'd6;
    build_model();
    chk("pin1_len", mdl.size(), 4);
    chk("pin1_e0", mdl[0].row * 256 + mdl[0].data, 2 * 256 + 3);
    chk("pin1_e1", mdl[1].row * 256 + mdl[1].data, 7 * 256 + 5);
    chk("pin1_e2", mdl[2].row * 65536 + mdl[2].col * 256 + mdl[2].data, 0 * 65536 + 2 * 256 + 4);
    chk("pin1_e3", mdl[3].row * 65536 + mdl[3].col * 256 + mdl[3].data, 1 * 65536 + 7 * 256 + 6);
    run_job(0, 0);
    clear_job();
    for (int i = 0; i < 16; i++) vec[i] = 8'(i + 1);
    mat[3][4] = 8'd9;
    build_model();
    chk("pin2_len", mdl.size(), 15);
    chk("pin2_ovf", int'(m_ovf), 1);
    chk("pin2_last_vec", mdl[13].row, 13);
    run_job(0, 0);
    clear_job();
    vec[2] = 8'd3;
    vec[7] = 8'd5;
    mat[0][2] = 8'd4;
    mat[1][7] = 8'd6;
    run_job(0, 0);
    clear_job();
    vec[5] = 8'd7;
    vec[30] = 8'd1;
    build_model();
    chk("pin3_len", mdl.size(), 0);
    run_job(0, 0);
    clear_job();
    vec[0] = 8'd1;
    for (int i = 0; i < 6; i++) mat[i][i * 3] = 8'(i + 10);
    run_job(1, 0);
    clear_job();
    vec[2] = 8'd3;
    vec[7] = 8'd5;
    mat[0][2] = 8'd4;
    mat[1][7] = 8'd6;
    run_job(0, 1);
    run_job(0, 0);
`ifdef SPMV_TX_COLFILTER_EN
    clear_job();
    vec[1] = 8'd5;
    mat[0][1] = 8'd2;
    mat[0][3] = 8'd9;
    build_model();
    chk("pin_cf_len", mdl.size(), 2);
    chk("pin_cf_col", mdl[1].col, 1);
    chk("pin_cf_ovf", int'(m_ovf), 0);
    run_job(0, 0);
`endif
    for (int k = 0; k < 10; k++) begin
      rand_job($urandom_range(5, 60), $urandom_range(5, 80));
      run_job(k % 3 == 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
